// File: rtl/sparc_alu_pkg.sv
// Shared definitions for the SPARC ALU multiply sequencer.
//   ALU_WIDTH  : operand width of the shared integer ALU
//   ALU_ADD_S  : ALU opcode for add with flag update
//   ALU_SUB    : ALU opcode for subtract without flag update
//   seq_state_t: multiply sequencer FSM states
package sparc_alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [5:0] ALU_ADD_S = 6'b010000;
  localparam logic [5:0] ALU_SUB   = 6'b000100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_STEP = 3'd1,
    ST_FIXA = 3'd2,
    ST_FIXB = 3'd3,
    ST_DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_port_mux.sv
// Selects who drives the shared ALU: the integer pipeline or the multiply
// sequencer. While the sequencer owns the ALU, any pipeline request is
// stalled.
// Ports:
//   seq_own                         : sequencer owns the ALU this cycle
//   seq_a/seq_b/seq_opcode/seq_carry: sequencer ALU operands
//   pipe_req                        : pipeline wants the ALU
//   pipe_a/pipe_b/pipe_opcode/pipe_carry: pipeline ALU operands
//   pipe_stall                      : pipeline request denied
//   alu_a/alu_b/alu_opcode/alu_carry: to the ALU
module alu_port_mux
  import sparc_alu_pkg::*;
(
  input  logic                 seq_own,
  input  logic [ALU_WIDTH-1:0] seq_a,
  input  logic [ALU_WIDTH-1:0] seq_b,
  input  logic [5:0]           seq_opcode,
  input  logic                 seq_carry,
  input  logic                 pipe_req,
  input  logic [ALU_WIDTH-1:0] pipe_a,
  input  logic [ALU_WIDTH-1:0] pipe_b,
  input  logic [5:0]           pipe_opcode,
  input  logic                 pipe_carry,
  output logic                 pipe_stall,
  output logic [ALU_WIDTH-1:0] alu_a,
  output logic [ALU_WIDTH-1:0] alu_b,
  output logic [5:0]           alu_opcode,
  output logic                 alu_carry
);

  assign alu_a      = seq_own ? seq_a      : pipe_a;
  assign alu_b      = seq_own ? seq_b      : pipe_b;
  assign alu_opcode = seq_own ? seq_opcode : pipe_opcode;
  assign alu_carry  = seq_own ? seq_carry  : pipe_carry;
  assign pipe_stall = seq_own & pipe_req;

endmodule

// File: rtl/alu_mul_sequencer.sv
// 32x32->64 multiply sequencer that borrows the shared SPARC ALU for
// STEPS shift-add iterations, plus two correction subtracts for signed
// operands. The pipeline is stalled while the sequencer owns the ALU.
// Ports:
//   clk, reset_n               : clock, async active-low reset
//   start, is_signed, op_a, op_b: multiply request and operands
//   ready, done                : idle / one-cycle product-valid pulse
//   prod_hi, prod_lo           : 64-bit product, held until next accept
//   pipe_*                     : pipeline ALU request, pipe_stall denies it
//   alu_*                      : shared ALU ports (result/carry come back)
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | ready; ALU passed through to pipeline
// STEP    | one shift-add iteration per cycle
// FIXA    | signed: hi -= (a[31] ? b : 0)
// FIXB    | signed: hi -= (b[31] ? a : 0)
// DONE    | done pulse, product valid; ALU passed through
module alu_mul_sequencer
  import sparc_alu_pkg::*;
#(
  parameter int STEPS = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [ALU_WIDTH-1:0] op_a,
  input  logic [ALU_WIDTH-1:0] op_b,
  output logic                 ready,
  output logic                 done,
  output logic [ALU_WIDTH-1:0] prod_hi,
  output logic [ALU_WIDTH-1:0] prod_lo,
  input  logic                 pipe_req,
  input  logic [ALU_WIDTH-1:0] pipe_a,
  input  logic [ALU_WIDTH-1:0] pipe_b,
  input  logic [5:0]           pipe_opcode,
  input  logic                 pipe_carry,
  output logic                 pipe_stall,
  output logic [ALU_WIDTH-1:0] alu_a,
  output logic [ALU_WIDTH-1:0] alu_b,
  output logic [5:0]           alu_opcode,
  output logic                 alu_carry,
  input  logic [ALU_WIDTH-1:0] alu_result,
  input  logic                 alu_c
);

  localparam int CW = $clog2(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  seq_state_t           state;
  logic [ALU_WIDTH-1:0] mcand;
  logic [ALU_WIDTH-1:0] b_orig;
  logic [ALU_WIDTH-1:0] hi;
  logic [ALU_WIDTH-1:0] lo;
  logic                 sgn;
  logic [CW-1:0]        count;

  logic                 seq_own;
  logic [ALU_WIDTH-1:0] seq_b;
  logic [5:0]           seq_opcode;
  logic [ALU_WIDTH-1:0] hi_step;
  logic [ALU_WIDTH-1:0] lo_step;

  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE);

  assign seq_own = (state == ST_STEP) || (state == ST_FIXA) || (state == ST_FIXB);

  always_comb begin
    seq_b      = '0;
    seq_opcode = ALU_SUB;
    unique case (state)
      ST_STEP: begin
        seq_b      = lo[0] ? mcand : '0;
        seq_opcode = ALU_ADD_S;
      end
      ST_FIXA: seq_b = mcand[ALU_WIDTH-1]  ? b_orig : '0;
      ST_FIXB: seq_b = b_orig[ALU_WIDTH-1] ? mcand  : '0;
      default: seq_b = '0;
    endcase
  end

  // 65-bit {carry, sum, lo} shifted right by one into the 64-bit {hi, lo}.
  assign hi_step = {alu_c, alu_result[ALU_WIDTH-1:1]};
  assign lo_step = {alu_result[0], lo[ALU_WIDTH-1:1]};

  alu_port_mux u_mux (
    .seq_own     (seq_own),
    .seq_a       (hi),
    .seq_b       (seq_b),
    .seq_opcode  (seq_opcode),
    .seq_carry   (1'b0),
    .pipe_req    (pipe_req),
    .pipe_a      (pipe_a),
    .pipe_b      (pipe_b),
    .pipe_opcode (pipe_opcode),
    .pipe_carry  (pipe_carry),
    .pipe_stall  (pipe_stall),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_carry   (alu_carry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      mcand   <= '0;
      b_orig  <= '0;
      hi      <= '0;
      lo      <= '0;
      sgn     <= 1'b0;
      count   <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= op_a;
            b_orig <= op_b;
            lo     <= op_b;
            hi     <= '0;
            sgn    <= is_signed;
            count  <= '0;
            state  <= ST_STEP;
          end
        end
        ST_STEP: begin
          hi    <= hi_step;
          lo    <= lo_step;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            if (sgn) begin
              state <= ST_FIXA;
            end else begin
              prod_hi <= hi_step;
              prod_lo <= lo_step;
              state   <= ST_DONE;
            end
          end
        end
        ST_FIXA: begin
          hi    <= alu_result;
          state <= ST_FIXB;
        end
        ST_FIXB: begin
          hi      <= alu_result;
          prod_hi <= alu_result;
          prod_lo <= lo;
          state   <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ready;
  logic        done;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;
  logic        pipe_req;
  logic [31:0] pipe_a;
  logic [31:0] pipe_b;
  logic [5:0]  pipe_opcode;
  logic        pipe_carry;
  logic        pipe_stall;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_opcode;
  logic        alu_carry;
  logic [31:0] alu_result;
  logic        alu_c;

  int vectors = 0;
  int miscompares = 0;

  alu_mul_sequencer #(.STEPS(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .is_signed   (is_signed),
    .op_a        (op_a),
    .op_b        (op_b),
    .ready       (ready),
    .done        (done),
    .prod_hi     (prod_hi),
    .prod_lo     (prod_lo),
    .pipe_req    (pipe_req),
    .pipe_a      (pipe_a),
    .pipe_b      (pipe_b),
    .pipe_opcode (pipe_opcode),
    .pipe_carry  (pipe_carry),
    .pipe_stall  (pipe_stall),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_carry   (alu_carry),
    .alu_result  (alu_result),
    .alu_c       (alu_c)
  );

  // Behavioural stand-in for the shared combinational ALU.
  always_comb begin
    alu_result = alu_a ^ alu_b;
    alu_c      = 1'b0;
    case (alu_opcode)
      6'b010000: {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_carry};
      6'b000100: alu_result = alu_a - alu_b;
      default:   alu_result = alu_a ^ alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
  task automatic run_mul(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] expv, input int lat,
                         input bit chk_pipe, input int stray_at, input bit start_in_done);
    int idx;
    idx = -1;
    start = 1'b1; is_signed = sgn; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; is_signed = ~sgn;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == stray_at) begin
        start = 1'b1; op_a = 32'd9; op_b = 32'd9;
      end else if (i == stray_at + 1) begin
        start = 1'b0;
      end
      if (chk_pipe) begin
        if (i < lat) begin
          check({tag, " stall"}, {63'd0, pipe_stall}, 64'd1);
          check({tag, " opc"}, {58'd0, alu_opcode}, (i < 32) ? 64'h10 : 64'h04);
        end else if (i == lat) begin
          check({tag, " done stall"}, {63'd0, pipe_stall}, 64'd0);
          check({tag, " done opc"}, {58'd0, alu_opcode}, {58'd0, pipe_opcode});
          check({tag, " done a"}, {32'd0, alu_a}, {32'd0, pipe_a});
          check({tag, " done carry"}, {63'd0, alu_carry}, {63'd0, pipe_carry});
        end
      end
      if (done === 1'b1) begin
        idx = i;
        break;
      end
    end
    check({tag, " latency"}, 64'(idx), 64'(lat));
    check({tag, " prod"}, {prod_hi, prod_lo}, expv);
    if (start_in_done) begin
      start = 1'b1; is_signed = 1'b0; op_a = 32'd2; op_b = 32'd3;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, " ready after"}, {63'd0, ready}, 64'd1);
    check({tag, " done after"}, {63'd0, done}, 64'd0);
    if (chk_pipe) begin
      check({tag, " idle stall"}, {63'd0, pipe_stall}, 64'd0);
      check({tag, " idle b"}, {32'd0, alu_b}, {32'd0, pipe_b});
    end
  endtask

  initial begin
    bit seen_done;
    reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    pipe_req = 1'b1; pipe_a = 32'hA5A5_0001; pipe_b = 32'h0F0F_0002;
    pipe_opcode = 6'b010010; pipe_carry = 1'b1;

    #12;
    check("rst ready", {63'd0, ready}, 64'd1);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst prod", {prod_hi, prod_lo}, 64'd0);
    check("rst stall", {63'd0, pipe_stall}, 64'd0);
    check("rst opc", {58'd0, alu_opcode}, 64'h12);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_mul("u3x5", 1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 32, 1'b0, -1, 1'b0);
    run_mul("uffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32, 1'b0, -1, 1'b0);
    run_mul("sm1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 34, 1'b0, -1, 1'b0);
    run_mul("s8x7", 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 34, 1'b1, -1, 1'b0);
    run_mul("u3x5pipe", 1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 32, 1'b1, -1, 1'b0);
    run_mul("busy_start", 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 32, 1'b0, 5, 1'b1);
    run_mul("after_done", 1'b0, 32'd2, 32'd3, 64'd6, 32, 1'b0, -1, 1'b0);
    run_mul("s_neg3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 34, 1'b0, -1, 1'b0);

    // Abort mid-sequence with reset.
    start = 1'b1; is_signed = 1'b0; op_a = 32'h1234; op_b = 32'h5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort ready", {63'd0, ready}, 64'd1);
    check("abort done", {63'd0, done}, 64'd0);
    check("abort prod", {prod_hi, prod_lo}, 64'd0);
    check("abort stall", {63'd0, pipe_stall}, 64'd0);
    check("abort opc", {58'd0, alu_opcode}, 64'h12);
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("abort no done", {63'd0, seen_done}, 64'd0);
    run_mul("u7x6", 1'b0, 32'd7, 32'd6, 64'd42, 32, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
